// File: rtl/nzp_pkg.sv
// Shared condition-code types and the bus-value classifier for the NZP unit.
package nzp_pkg;

  typedef logic [2:0] cc_t;

  localparam cc_t CC_NONE = 3'b000;
  localparam cc_t CC_P    = 3'b001;
  localparam cc_t CC_Z    = 3'b010;
  localparam cc_t CC_N    = 3'b100;

  // Which source, if any, updates the CC register this cycle.
  typedef enum logic [1:0] {
    CC_SRC_HOLD,
    CC_SRC_STACK,
    CC_SRC_BUS
  } cc_src_e;

  // The caller zero-extends value, so the zero test over all 64 bits is exact.
  function automatic cc_t classify(input logic [63:0] value, input int unsigned width);
    if (value[width-1])
      return CC_N;
    else if (value == '0)
      return CC_Z;
    else
      return CC_P;
  endfunction

endpackage

// File: rtl/nzp_cc_unit_if.sv
// Control/status bundle between the control FSM (master) and the NZP unit (slave).
interface nzp_cc_unit_if
  import nzp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             Load;
  logic [WIDTH-1:0] DIn;
  logic [2:0]       IR_nzp;
  logic             LD_BEN;
  logic             Push;
  logic             Pop;
  cc_t              CC;
  logic             BEN;
  logic             Full;
  logic             Empty;
  logic [CW-1:0]    Count;
  logic             Err;

  modport master (
    output Load, DIn, IR_nzp, LD_BEN, Push, Pop,
    input  CC, BEN, Full, Empty, Count, Err
  );

  modport slave (
    input  Load, DIn, IR_nzp, LD_BEN, Push, Pop,
    output CC, BEN, Full, Empty, Count, Err
  );
endinterface

// File: rtl/nzp_cc_stack.sv
// LIFO of saved condition codes; push/pop are qualified here against Full/Empty and each other.
module nzp_cc_stack
  import nzp_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  cc_t           din,
  output cc_t           top,
  output logic          pop_ok,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cc_t           mem [DEPTH];
  logic [CW-1:0] count_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // Simultaneous push and pop cancel each other entirely.
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign wr_idx  = AW'(count_q);
  assign rd_idx  = AW'(count_q - CW'(1));
  assign top     = mem[rd_idx];
  assign pop_ok  = do_pop;
  assign count   = count_q;

  always_ff @(posedge Clk) begin
    if (!Reset)
      count_q <= '0;
    else if (do_push)
      count_q <= count_q + CW'(1);
    else if (do_pop)
      count_q <= count_q - CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (do_push)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/nzp_cc_unit.sv
// Condition-code unit: NZP flags, registered BEN and a saved-CC stack for interrupt entry/RTI.
// Define NZP_STACK_ERR_EN to enable the sticky stack-misuse flag on Err.
module nzp_cc_unit
  import nzp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  nzp_cc_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  cc_t           cc_q;
  cc_t           stack_top;
  cc_src_e       cc_src;
  logic          ben_q;
  logic          pop_ok;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  nzp_cc_stack #(.DEPTH(DEPTH)) u_stack (
    .Clk    (Clk),
    .Reset  (Reset),
    .push   (bus.Push),
    .pop    (bus.Pop),
    .din    (cc_q),
    .top    (stack_top),
    .pop_ok (pop_ok),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // A successful restore wins over a bus load issued in the same cycle.
  always_comb begin
    cc_src = CC_SRC_HOLD;
    if (pop_ok)
      cc_src = CC_SRC_STACK;
    else if (bus.Load)
      cc_src = CC_SRC_BUS;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cc_q  <= CC_NONE;
      ben_q <= 1'b0;
    end else begin
      unique case (cc_src)
        CC_SRC_STACK: cc_q <= stack_top;
        CC_SRC_BUS:   cc_q <= classify(64'(bus.DIn), WIDTH);
        default:      cc_q <= cc_q;
      endcase
      if (bus.LD_BEN)
        ben_q <= |(bus.IR_nzp & cc_q);
    end
  end

`ifdef NZP_STACK_ERR_EN
  logic err_q;
  logic misuse;

  assign misuse = (bus.Push & full) | (bus.Pop & empty) | (bus.Push & bus.Pop);

  always_ff @(posedge Clk) begin
    if (!Reset)
      err_q <= 1'b0;
    else if (misuse)
      err_q <= 1'b1;
  end

  assign bus.Err = err_q;
`else
  assign bus.Err = 1'b0;
`endif

  assign bus.CC    = cc_q;
  assign bus.BEN   = ben_q;
  assign bus.Count = count;
  assign bus.Full  = full;
  assign bus.Empty = empty;

endmodule

// File: tb/tb_nzp_cc_unit.sv
// Directed scoreboard bench for nzp_cc_unit (WIDTH=16/DEPTH=4 plus an 8-bit instance).
module tb_nzp_cc_unit;
  import nzp_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

`ifdef NZP_STACK_ERR_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif

  typedef struct {
    string       tag;
    cc_t         cc;
    logic        ben;
    int unsigned cnt;
    logic        err;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  nzp_cc_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();
  nzp_cc_unit_if #(.WIDTH(8), .DEPTH(2)) bus8 ();

  nzp_cc_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  nzp_cc_unit #(.WIDTH(8), .DEPTH(2)) dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus8.slave)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".CC"},    32'(bus.CC),    32'(e.cc));
    check({e.tag, ".BEN"},   32'(bus.BEN),   32'(e.ben));
    check({e.tag, ".Count"}, 32'(bus.Count), 32'(e.cnt));
    check({e.tag, ".Full"},  32'(bus.Full),  32'(e.cnt == D));
    check({e.tag, ".Empty"}, 32'(bus.Empty), 32'(e.cnt == 0));
    check({e.tag, ".Err"},   32'(bus.Err),   32'(e.err));
  endtask

  // Drive one cycle of stimulus, queue the expectation, sample 1 time unit after the edge.
  task automatic step(input string tag, input logic rst, input logic ld, input logic [15:0] din,
                      input logic [2:0] nzp, input logic ldben, input logic push, input logic pop,
                      input cc_t ecc, input logic eben, input int unsigned ecnt, input logic eerr);
    exp_t e;
    Reset       = rst;
    bus.Load    = ld;
    bus.DIn     = din;
    bus.IR_nzp  = nzp;
    bus.LD_BEN  = ldben;
    bus.Push    = push;
    bus.Pop     = pop;
    e.tag = tag; e.cc = ecc; e.ben = eben; e.cnt = ecnt; e.err = eerr;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    compare();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus8.Load = 1'b0; bus8.DIn = '0; bus8.IR_nzp = '0;
    bus8.LD_BEN = 1'b0; bus8.Push = 1'b0; bus8.Pop = 1'b0;

    //    tag           rst ld din      nzp    ldb psh pop  eCC      eBEN ecnt eErr
    step("reset",       0,  0, 16'h0,   3'b000, 0,  0,  0,  CC_NONE, 0,   0,   0);
    step("reset_hold",  0,  1, 16'h8000,3'b111, 1,  1,  0,  CC_NONE, 0,   0,   0);
    step("idle",        1,  0, 16'h0,   3'b000, 0,  0,  0,  CC_NONE, 0,   0,   0);
    step("load_neg",    1,  1, 16'h8000,3'b000, 0,  0,  0,  CC_N,    0,   0,   0);
    step("load_zero",   1,  1, 16'h0000,3'b000, 0,  0,  0,  CC_Z,    0,   0,   0);

    bus8.Load = 1'b1; bus8.DIn = 8'h7F;
    step("load_pos",    1,  1, 16'h0001,3'b000, 0,  0,  0,  CC_P,    0,   0,   0);
    check("w8_7F.CC", 32'(bus8.CC), 32'(CC_P));
    bus8.DIn = 8'h80;
    step("load_zero2",  1,  1, 16'h0000,3'b000, 0,  0,  0,  CC_Z,    0,   0,   0);
    check("w8_80.CC", 32'(bus8.CC), 32'(CC_N));
    bus8.Load = 1'b0;

    // BEN uses the CC held before the edge (Z & 011 -> 1), while CC takes the new load.
    step("ben_oldcc",   1,  1, 16'hFFFF,3'b011, 1,  0,  0,  CC_N,    1,   0,   0);
    step("ben_miss",    1,  0, 16'h0,   3'b011, 1,  0,  0,  CC_N,    0,   0,   0);
    step("ben_hit",     1,  0, 16'h0,   3'b100, 1,  0,  0,  CC_N,    1,   0,   0);
    step("ben_hold",    1,  0, 16'h0,   3'b000, 0,  0,  0,  CC_N,    1,   0,   0);

    // Fill stack with 100,010,001,100 via Push+Load pairs.
    step("push1_load",  1,  1, 16'h0000,3'b000, 0,  1,  0,  CC_Z,    1,   1,   0);
    step("push2_load",  1,  1, 16'h0001,3'b000, 0,  1,  0,  CC_P,    1,   2,   0);
    step("push3_load",  1,  1, 16'h8000,3'b000, 0,  1,  0,  CC_N,    1,   3,   0);
    step("push4",       1,  0, 16'h0,   3'b000, 0,  1,  0,  CC_N,    1,   4,   0);
    step("push_full",   1,  1, 16'h0000,3'b000, 0,  1,  0,  CC_Z,    1,   4,   E);

    step("pop1",        1,  0, 16'h0,   3'b000, 0,  0,  1,  CC_N,    1,   3,   E);
    step("pop2",        1,  0, 16'h0,   3'b000, 0,  0,  1,  CC_P,    1,   2,   E);
    step("pop3",        1,  0, 16'h0,   3'b000, 0,  0,  1,  CC_Z,    1,   1,   E);
    step("pop4",        1,  0, 16'h0,   3'b000, 0,  0,  1,  CC_N,    1,   0,   E);
    step("pop_empty",   1,  0, 16'h0,   3'b000, 0,  0,  1,  CC_N,    1,   0,   E);
    step("pop_empty_ld",1,  1, 16'h0001,3'b000, 0,  0,  1,  CC_P,    1,   0,   E);

    // Pop beats Load; Push+Pop cancels while Load still applies.
    step("push_a",      1,  0, 16'h0,   3'b000, 0,  1,  0,  CC_P,    1,   1,   E);
    step("load_n",      1,  1, 16'h8000,3'b000, 0,  0,  0,  CC_N,    1,   1,   E);
    step("push_b",      1,  0, 16'h0,   3'b000, 0,  1,  0,  CC_N,    1,   2,   E);
    step("load_p",      1,  1, 16'h0001,3'b000, 0,  0,  0,  CC_P,    1,   2,   E);
    step("pop_over_ld", 1,  1, 16'h0000,3'b000, 0,  0,  1,  CC_N,    1,   1,   E);
    step("pushpop_ld",  1,  1, 16'h0000,3'b000, 0,  1,  1,  CC_Z,    1,   1,   E);
    step("push_c",      1,  0, 16'h0,   3'b000, 0,  1,  0,  CC_Z,    1,   2,   E);
    step("push_d",      1,  0, 16'h0,   3'b000, 0,  1,  0,  CC_Z,    1,   3,   E);

    // Reset mid-sequence with Push/Load/LD_BEN active.
    step("reset_mid",   0,  1, 16'h8000,3'b111, 1,  1,  0,  CC_NONE, 0,   0,   0);
    step("push_nul",    1,  0, 16'h0,   3'b000, 0,  1,  0,  CC_NONE, 0,   1,   0);
    step("pushpop_err", 1,  0, 16'h0,   3'b000, 0,  1,  1,  CC_NONE, 0,   1,   E);
    step("load_n2",     1,  1, 16'h8000,3'b000, 0,  0,  0,  CC_N,    0,   1,   E);
    step("pop_nul",     1,  0, 16'h0,   3'b000, 0,  0,  1,  CC_NONE, 0,   0,   E);
    step("reset_end",   0,  0, 16'h0,   3'b000, 0,  0,  0,  CC_NONE, 0,   0,   0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
